// File: rtl/uart_cmd_seq_pkg.sv
// Shared types for the UART command sequencer.
// UART_CMD_CHKSUM_EN adds a fourth checksum byte to every frame.
package uart_cmd_pkg;

  typedef enum logic [2:0] {IDLE, B1, B2, CHK, HOLD} state_t;

  typedef logic [7:0] opcode_t;

`ifdef UART_CMD_CHKSUM_EN
  localparam int FRAME_BYTES = 4;
`else
  localparam int FRAME_BYTES = 3;
`endif

  // Checksum byte is the modulo-256 sum of opcode, data_hi and data_lo.
  function automatic logic [7:0] frame_sum(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2);
    return b0 + b1 + b2;
  endfunction

endpackage

// File: rtl/uart_cmd_seq_if.sv
// Receiver-side and decoder-side signals of the UART command sequencer.
interface uart_cmd_seq_if;
  import uart_cmd_pkg::*;

  // rx byte is taken in the cycle rdy&clr_rdy is high; a frame is consumed on cmd_vld&cmd_ack.
  logic        rdy;
  logic [7:0]  rx_byte;
  logic        clr_rdy;
  logic        cmd_vld;
  logic        cmd_ack;
  opcode_t     opcode;
  logic [15:0] data;
  logic        frm_err;

  modport master (
    input  rdy, rx_byte, cmd_ack,
    output clr_rdy, cmd_vld, opcode, data, frm_err
  );

  modport slave (
    output rdy, rx_byte, cmd_ack,
    input  clr_rdy, cmd_vld, opcode, data, frm_err
  );

endinterface

// File: rtl/uart_cmd_seq_tmr.sv
// Inter-byte timeout counter: saturates at TO_CYCLES, flags the last cycle before expiry.
module cmd_timeout_tmr #(
    parameter int TO_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(TO_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_TOP)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_cmd_seq.sv
// Assembles UART bytes into opcode/data frames and hands them to the command decoder.
// UART_CMD_CHKSUM_EN selects 4-byte frames with a trailing checksum byte.
module uart_cmd_seq
    import uart_cmd_pkg::*;
#(
    parameter int TO_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cmd_seq_if.master bus,
    output state_t         state_dbg
);

    state_t      state, state_nxt;
    opcode_t     op_s;
    logic [7:0]  hi_s;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]  lo_s;
`endif
    opcode_t     opcode_r;
    logic [15:0] data_r;
    logic        cmd_vld_r, frm_err_r;
    logic        accept, in_frame, expired, timeout;
    logic        frame_done, chk_fail;

    assign in_frame = (state inside {B1, B2, CHK});
    assign accept   = bus.rdy && (state inside {IDLE, B1, B2, CHK});
    assign timeout  = in_frame && expired && !accept;

    cmd_timeout_tmr #(.TO_CYCLES(TO_CYCLES)) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept || timeout || !in_frame),
        .en      (in_frame),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        chk_fail   = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = B1;
            B1: begin
                if (accept)       state_nxt = B2;
                else if (timeout) state_nxt = IDLE;
            end
            B2: begin
                if (accept) begin
`ifdef UART_CMD_CHKSUM_EN
                    state_nxt  = CHK;
`else
                    state_nxt  = HOLD;
                    frame_done = 1'b1;
`endif
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            CHK: begin
                if (accept) begin
                    if (bus.rx_byte == frame_sum(op_s, hi_s, lo_s)) begin
                        state_nxt  = HOLD;
                        frame_done = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        chk_fail  = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
`else
            CHK: state_nxt = IDLE;
`endif
            HOLD: if (bus.cmd_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Partial bytes live in shadow registers so a timed-out frame never disturbs opcode/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_s      <= '0;
            hi_s      <= '0;
`ifdef UART_CMD_CHKSUM_EN
            lo_s      <= '0;
`endif
            opcode_r  <= '0;
            data_r    <= '0;
            cmd_vld_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            cmd_vld_r <= (state_nxt == HOLD);
            frm_err_r <= timeout || chk_fail;
            if (accept) begin
                case (state)
                    IDLE: op_s <= bus.rx_byte;
                    B1:   hi_s <= bus.rx_byte;
`ifdef UART_CMD_CHKSUM_EN
                    B2:   lo_s <= bus.rx_byte;
`endif
                    default: ;
                endcase
            end
            if (frame_done) begin
                opcode_r <= op_s;
`ifdef UART_CMD_CHKSUM_EN
                data_r   <= {hi_s, lo_s};
`else
                data_r   <= {hi_s, bus.rx_byte};
`endif
            end
        end
    end

    assign bus.clr_rdy = accept;
    assign bus.cmd_vld = cmd_vld_r;
    assign bus.opcode  = opcode_r;
    assign bus.data    = data_r;
    assign bus.frm_err = frm_err_r;
    assign state_dbg   = state;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Bench for uart_cmd_seq: directed scenarios plus random byte streams against a frame-level model.
module tb_uart_cmd_seq;
  import uart_cmd_pkg::*;

  localparam int TO = 64;
`ifdef UART_CMD_CHKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic   clk = 1'b0;
  logic   rst_n;
  state_t state_dbg;

  uart_cmd_seq_if bus();

  uart_cmd_seq #(.TO_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / model state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int clr_cnt = 0;
  int vld_cnt = 0;
  int ferr_cnt = 0;
  bit clr_s = 1'b0;
  bit ack_rand = 1'b0;

  logic [7:0]  part_q[$];
  logic [23:0] exp_q[$];
  bit          m_hold = 1'b0;
  bit          m_err = 1'b0;
  logic [7:0]  m_op = '0;
  logic [15:0] m_data = '0;
  int          m_idle = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard (evaluated mid-cycle) ----------------
  // A partial frame is dropped once TO consecutive edges pass with no byte taken.
  always @(negedge clk) begin
    bit         was_hold;
    bit         exp_clr;
    logic [7:0] s;
    if (!rst_n) begin
      part_q.delete();
      exp_q.delete();
      m_hold = 1'b0;
      m_err  = 1'b0;
      m_op   = '0;
      m_data = '0;
      m_idle = 0;
      clr_s  = 1'b0;
      check("rst_cmd_vld", bus.cmd_vld, 1'b0);
      check("rst_frm_err", bus.frm_err, 1'b0);
      check("rst_opcode", bus.opcode, 8'h00);
      check("rst_data", bus.data, 16'h0000);
    end else begin
      check("cmd_vld", bus.cmd_vld, m_hold);
      check("frm_err", bus.frm_err, m_err);
      check("opcode", bus.opcode, m_op);
      check("data", bus.data, m_data);
      was_hold = m_hold;
      exp_clr  = bus.rdy && !was_hold;
      check("clr_rdy", bus.clr_rdy, exp_clr);
      clr_s = bus.clr_rdy;
      if (bus.clr_rdy) clr_cnt++;
      if (bus.cmd_vld) vld_cnt++;
      if (bus.frm_err) ferr_cnt++;
      if (bus.cmd_vld && bus.cmd_ack) begin
        check("frame_pending", exp_q.size(), 1);
        if (exp_q.size() != 0) check("frame", {bus.opcode, bus.data}, exp_q.pop_front());
      end
      m_err = 1'b0;
      if (was_hold && bus.cmd_ack) m_hold = 1'b0;
      if (exp_clr) begin
        part_q.push_back(bus.rx_byte);
        m_idle = 0;
        if (part_q.size() == FB) begin
          s = part_q[0] + part_q[1] + part_q[2];
`ifdef UART_CMD_CHKSUM_EN
          if (s == part_q[3]) begin
`else
          if (s == s) begin
`endif
            m_hold = 1'b1;
            m_op   = part_q[0];
            m_data = {part_q[1], part_q[2]};
            exp_q.push_back({m_op, m_data});
          end else begin
            m_err = 1'b1;
          end
          part_q.delete();
        end
      end else if (part_q.size() != 0) begin
        if (m_idle == TO - 1) begin
          part_q.delete();
          m_err  = 1'b1;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Receiver model: rdy falls on the edge after clr_rdy was seen high.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (clr_s) bus.rdy = 1'b0;
      if (ack_rand) bus.cmd_ack = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    while (bus.rdy && n < 300) begin
      tick(1);
      n++;
    end
    check("rx_free", bus.rdy, 1'b0);
    bus.rx_byte = b;
    bus.rdy     = 1'b1;
  endtask

  task automatic wait_taken();
    int n = 0;
    while (bus.rdy && n < 300) begin
      tick(1);
      n++;
    end
    check("byte_taken", bus.rdy, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int gap);
    logic [7:0] fb[4];
    fb = '{b0, b1, b2, 8'(b0 + b1 + b2)};
    for (int i = 0; i < FB; i++) begin
      put_byte(fb[i]);
      wait_taken();
      tick(gap);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb[4];
    int         nb;
    rst_n       = 1'b0;
    bus.rdy     = 1'b0;
    bus.rx_byte = '0;
    bus.cmd_ack = 1'b0;
    tick(3);
    check("reset_state", state_dbg, IDLE);
    check("reset_clr_rdy", bus.clr_rdy, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Basic frame, ack tied high.
    bus.cmd_ack = 1'b1;
    clr_cnt = 0;
    vld_cnt = 0;
    send_frame(8'h05, 8'h12, 8'h34, 20);
    tick(3);
    check("t1_clr_pulses", clr_cnt, FB);
    check("t1_vld_cycles", vld_cnt, 1);
    check("t1_opcode", bus.opcode, 8'h05);
    check("t1_data", bus.data, 16'h1234);

    // Backpressure: frame held unacknowledged while the next byte waits.
    bus.cmd_ack = 1'b0;
    send_frame(8'hA0, 8'hBE, 8'hEF, 2);
    put_byte(8'h01);
    clr_cnt = 0;
    vld_cnt = 0;
    tick(30);
    check("t2_vld_held", vld_cnt, 30);
    check("t2_no_clr", clr_cnt, 0);
    check("t2_byte_pending", bus.rdy, 1'b1);
    check("t2_opcode", bus.opcode, 8'hA0);
    check("t2_data", bus.data, 16'hBEEF);
    bus.cmd_ack = 1'b1;
    tick(1);
    check("t2_idle_after_ack", state_dbg, IDLE);
    check("t2_clr_in_idle", bus.clr_rdy, 1'b1);
    wait_taken();
    put_byte(8'h02);
    wait_taken();
    put_byte(8'h03);
    wait_taken();
`ifdef UART_CMD_CHKSUM_EN
    put_byte(8'h06);
    wait_taken();
`endif
    tick(3);
    check("t2_next_opcode", bus.opcode, 8'h01);
    check("t2_next_data", bus.data, 16'h0203);

    // Timeout discards a partial frame.
    ferr_cnt = 0;
    vld_cnt  = 0;
    put_byte(8'h11);
    wait_taken();
    put_byte(8'h22);
    wait_taken();
    tick(TO + 5);
    check("t3_frm_err_pulse", ferr_cnt, 1);
    check("t3_no_vld", vld_cnt, 0);
    check("t3_state_idle", state_dbg, IDLE);
    check("t3_keep_opcode", bus.opcode, 8'h01);
    send_frame(8'h33, 8'h44, 8'h55, 1);
    tick(3);
    check("t3_opcode", bus.opcode, 8'h33);
    check("t3_data", bus.data, 16'h4455);
    check("t3_single_err", ferr_cnt, 1);

    // Byte arrives on the exact timeout cycle: accept wins.
    ferr_cnt = 0;
    put_byte(8'h11);
    wait_taken();
    tick(TO - 1);
    put_byte(8'h22);
    wait_taken();
    put_byte(8'h33);
    wait_taken();
`ifdef UART_CMD_CHKSUM_EN
    put_byte(8'h66);
    wait_taken();
`endif
    tick(3);
    check("t4_no_err", ferr_cnt, 0);
    check("t4_opcode", bus.opcode, 8'h11);
    check("t4_data", bus.data, 16'h2233);

    // Asynchronous reset mid-frame, then while holding a frame.
    put_byte(8'hAA);
    wait_taken();
    put_byte(8'hBB);
    wait_taken();
    tick(2);
    check("t5_in_b2", state_dbg, B2);
    rst_n = 1'b0;
    #1;
    check("t5_b2_rst_state", state_dbg, IDLE);
    check("t5_b2_rst_opcode", bus.opcode, 8'h00);
    tick(1);
    rst_n = 1'b1;
    bus.cmd_ack = 1'b0;
    send_frame(8'hC1, 8'hC2, 8'hC3, 0);
    tick(2);
    check("t5_holding", bus.cmd_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_hold_rst_vld", bus.cmd_vld, 1'b0);
    check("t5_hold_rst_data", bus.data, 16'h0000);
    tick(1);
    rst_n = 1'b1;
    bus.cmd_ack = 1'b1;
    send_frame(8'h0D, 8'h0E, 8'h0F, 3);
    tick(3);
    check("t5_opcode", bus.opcode, 8'h0D);
    check("t5_data", bus.data, 16'h0E0F);

`ifdef UART_CMD_CHKSUM_EN
    // Checksum match and mismatch.
    vld_cnt  = 0;
    ferr_cnt = 0;
    rb = '{8'h01, 8'h02, 8'h03, 8'h06};
    for (int i = 0; i < 4; i++) begin put_byte(rb[i]); wait_taken(); end
    tick(3);
    check("t6_good_vld", vld_cnt, 1);
    check("t6_good_data", bus.data, 16'h0203);
    rb = '{8'h01, 8'h02, 8'h03, 8'h07};
    for (int i = 0; i < 4; i++) begin put_byte(rb[i]); wait_taken(); end
    tick(3);
    check("t6_bad_err", ferr_cnt, 1);
    check("t6_bad_no_vld", vld_cnt, 1);
`endif

    // Random byte streams, random ack, occasional timeouts.
    ack_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      nb = $urandom_range(1, FB);
      for (int j = 0; j < 4; j++) rb[j] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) rb[3] = 8'(rb[0] + rb[1] + rb[2]);
      for (int j = 0; j < nb; j++) begin
        put_byte(rb[j]);
        wait_taken();
        if ($urandom_range(0, 5) == 0) tick($urandom_range(TO - 8, TO + 8));
        else tick($urandom_range(0, 20));
      end
      tick($urandom_range(0, 10));
    end

    ack_rand    = 1'b0;
    bus.cmd_ack = 1'b1;
    tick(TO + 10);
    check("frames_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
